rca_burst_accumulator: RTL and testbench

- Downstream consumer of the team's 6-bit ripple-carry adder with overflow detection.
- Accepts a burst of signed 6-bit operands over a valid/ready handshake and accumulates them into a registered 6-bit sum.
- For each burst it tracks signed overflow (optional saturation, sticky flag, event count) and presents one result beat over a valid/ready output handshake.

---
 rtl/rca_burst_accumulator_if.sv | 26 ++
 rtl/rca_burst_accumulator.sv | 124 ++++++++++++
 tb/tb_rca_burst_accumulator.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rca_burst_accumulator_if.sv
// Operand-in and result-out valid/ready handshakes for the burst accumulator.
interface rca_burst_accumulator_if #(
    parameter int WIDTH = 6,
    parameter int CNT_W = 4
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             in_last;
    logic             sat_en;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_overflow;
    logic [CNT_W-1:0] out_ovf_count;

    modport master (
        output in_valid, in_data, in_last, sat_en, out_ready,
        input  in_ready, out_valid, out_data, out_overflow, out_ovf_count
    );

    modport slave (
        input  in_valid, in_data, in_last, sat_en, out_ready,
        output in_ready, out_valid, out_data, out_overflow, out_ovf_count
    );
endinterface

// File: rtl/rca_burst_accumulator.sv
// Accumulates a burst of signed operands through a ripple-carry adder and
// reports the burst sum with overflow flag and saturating overflow count.
//
// state | meaning
// ACC   | accepting operand beats, in_ready=1
// OUT   | holding the burst result, out_valid=1 until out_ready
module rca_burst_accumulator #(
    parameter int WIDTH = 6,
    parameter int CNT_W = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    rca_burst_accumulator_if.slave bus
);
    localparam logic [WIDTH-1:0] SAT_POS = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] SAT_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic {
        ACC = 1'b0,
        OUT = 1'b1
    } state_t;

    state_t           state;
    state_t           state_next;

    logic [WIDTH-1:0] acc;
    logic             ovf_sticky;
    logic [CNT_W-1:0] ovf_cnt;

    logic [WIDTH:0]   carry;
    logic [WIDTH-1:0] raw_sum;
    logic [WIDTH-1:0] sum;
    logic             ovf;
    logic [CNT_W-1:0] cnt_next;
    logic             accept;
    logic             out_fire;

    assign accept   = bus.in_valid && (state == ACC);
    assign out_fire = bus.out_ready && (state == OUT);

    always_comb begin
        carry   = '0;
        raw_sum = '0;
        for (int i = 0; i < WIDTH; i++) begin
            raw_sum[i]   = acc[i] ^ bus.in_data[i] ^ carry[i];
            carry[i+1]   = (acc[i] & bus.in_data[i]) | (carry[i] & (acc[i] ^ bus.in_data[i]));
        end
    end

    // Signed overflow: carry into the sign bit disagrees with carry out of it.
    assign ovf = carry[WIDTH] ^ carry[WIDTH-1];

    always_comb begin
        sum = raw_sum;
        if (ovf && bus.sat_en) begin
            sum = acc[WIDTH-1] ? SAT_NEG : SAT_POS;
        end
    end

    always_comb begin
        cnt_next = ovf_cnt;
        if (ovf && (ovf_cnt != {CNT_W{1'b1}})) begin
            cnt_next = ovf_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ACC;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next    = state;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        case (state)
            ACC: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid && bus.in_last) begin
                    state_next = OUT;
                end
            end
            OUT: begin
                bus.out_valid = 1'b1;
                if (bus.out_ready) begin
                    state_next = ACC;
                end
            end
            default: state_next = ACC;
        endcase
    end

    // The final beat lands straight in the output registers; the running
    // state is cleared only once the result has been taken.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc               <= '0;
            ovf_sticky        <= 1'b0;
            ovf_cnt           <= '0;
            bus.out_data      <= '0;
            bus.out_overflow  <= 1'b0;
            bus.out_ovf_count <= '0;
        end else if (accept) begin
            ovf_cnt <= cnt_next;
            if (ovf) begin
                ovf_sticky <= 1'b1;
            end
            if (bus.in_last) begin
                bus.out_data      <= sum;
                bus.out_overflow  <= ovf_sticky | ovf;
                bus.out_ovf_count <= cnt_next;
            end else begin
                acc <= sum;
            end
        end else if (out_fire) begin
            acc        <= '0;
            ovf_sticky <= 1'b0;
            ovf_cnt    <= '0;
        end
    end
endmodule

// File: tb/tb_rca_burst_accumulator.sv
// Directed bench for the burst accumulator with hand-computed expectations.
module tb_rca_burst_accumulator;
    localparam int WIDTH = 6;
    localparam int CNT_W = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    rca_burst_accumulator_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

    rca_burst_accumulator #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic beat(input logic [WIDTH-1:0] d, input logic last, input logic sat);
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_last  = last;
        bus.sat_en   = sat;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.in_data  = 'x;
        bus.in_last  = 1'bx;
        bus.sat_en   = 1'bx;
    endtask

    task automatic take_result();
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++; $display("FAIL reset_in_ready: got %b want 1", bus.in_ready);
        end
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid);
        end
        checks++;
        if (bus.out_data !== 6'd0) begin
            errors++; $display("FAIL reset_out_data: got %0d want 0", bus.out_data);
        end
        checks++;
        if (bus.out_overflow !== 1'b0) begin
            errors++; $display("FAIL reset_out_overflow: got %b want 0", bus.out_overflow);
        end
        checks++;
        if (bus.out_ovf_count !== 4'd0) begin
            errors++; $display("FAIL reset_out_ovf_count: got %0d want 0", bus.out_ovf_count);
        end

        beat(6'd5, 1'b0, 1'b0);
        beat(6'd7, 1'b0, 1'b0);
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++; $display("FAIL midreset_out_valid: got %b want 0", bus.out_valid);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        beat(6'd3, 1'b1, 1'b0);
        checks++;
        if (bus.out_valid !== 1'b1) begin
            errors++; $display("FAIL midreset_valid: got %b want 1", bus.out_valid);
        end
        checks++;
        if (bus.out_data !== 6'd3) begin
            errors++; $display("FAIL midreset_data: got %0d want 3", $signed(bus.out_data));
        end
        checks++;
        if (bus.out_overflow !== 1'b0) begin
            errors++; $display("FAIL midreset_overflow: got %b want 0", bus.out_overflow);
        end
        take_result();
    endtask

    task automatic test_no_overflow();
        beat(6'd5, 1'b0, 1'b0);
        beat(6'd10, 1'b0, 1'b0);
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++; $display("FAIL noovf_early_valid: got %b want 0", bus.out_valid);
        end
        beat(6'(-3), 1'b1, 1'b0);
        checks++;
        if (bus.out_valid !== 1'b1) begin
            errors++; $display("FAIL noovf_valid: got %b want 1", bus.out_valid);
        end
        checks++;
        if (bus.in_ready !== 1'b0) begin
            errors++; $display("FAIL noovf_in_ready: got %b want 0", bus.in_ready);
        end
        checks++;
        if (bus.out_data !== 6'd12) begin
            errors++; $display("FAIL noovf_data: got %0d want 12", $signed(bus.out_data));
        end
        checks++;
        if (bus.out_overflow !== 1'b0 || bus.out_ovf_count !== 4'd0) begin
            errors++; $display("FAIL noovf_flags: got ovf=%b cnt=%0d want ovf=0 cnt=0",
                               bus.out_overflow, bus.out_ovf_count);
        end
        take_result();
        checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            errors++; $display("FAIL noovf_return: got valid=%b ready=%b want valid=0 ready=1",
                               bus.out_valid, bus.in_ready);
        end
    endtask

    task automatic test_wrap();
        beat(6'd20, 1'b0, 1'b0);
        beat(6'd20, 1'b1, 1'b0);
        checks++;
        if (bus.out_data !== 6'b101000) begin
            errors++; $display("FAIL wrap_data: got %b want 101000", bus.out_data);
        end
        checks++;
        if (bus.out_overflow !== 1'b1) begin
            errors++; $display("FAIL wrap_overflow: got %b want 1", bus.out_overflow);
        end
        checks++;
        if (bus.out_ovf_count !== 4'd1) begin
            errors++; $display("FAIL wrap_count: got %0d want 1", bus.out_ovf_count);
        end
        take_result();
    endtask

    task automatic test_saturation();
        beat(6'd20, 1'b0, 1'b1);
        beat(6'd20, 1'b1, 1'b1);
        checks++;
        if (bus.out_data !== 6'd31) begin
            errors++; $display("FAIL satpos_data: got %0d want 31", $signed(bus.out_data));
        end
        checks++;
        if (bus.out_overflow !== 1'b1 || bus.out_ovf_count !== 4'd1) begin
            errors++; $display("FAIL satpos_flags: got ovf=%b cnt=%0d want ovf=1 cnt=1",
                               bus.out_overflow, bus.out_ovf_count);
        end
        take_result();

        beat(6'(-20), 1'b0, 1'b1);
        beat(6'(-20), 1'b0, 1'b1);
        beat(6'(-10), 1'b1, 1'b1);
        checks++;
        if (bus.out_data !== 6'b100000) begin
            errors++; $display("FAIL satneg_data: got %0d want -32", $signed(bus.out_data));
        end
        checks++;
        if (bus.out_overflow !== 1'b1) begin
            errors++; $display("FAIL satneg_overflow: got %b want 1", bus.out_overflow);
        end
        checks++;
        if (bus.out_ovf_count !== 4'd2) begin
            errors++; $display("FAIL satneg_count: got %0d want 2", bus.out_ovf_count);
        end
        take_result();
    endtask

    task automatic test_counter_saturation();
        beat(6'd31, 1'b0, 1'b1);
        for (int i = 0; i < 17; i++) begin
            beat(6'd31, (i == 16), 1'b1);
        end
        checks++;
        if (bus.out_ovf_count !== 4'd15) begin
            errors++; $display("FAIL cntsat_count: got %0d want 15", bus.out_ovf_count);
        end
        checks++;
        if (bus.out_data !== 6'd31) begin
            errors++; $display("FAIL cntsat_data: got %0d want 31", $signed(bus.out_data));
        end
        checks++;
        if (bus.out_overflow !== 1'b1) begin
            errors++; $display("FAIL cntsat_overflow: got %b want 1", bus.out_overflow);
        end
        take_result();
    endtask

    task automatic test_backpressure();
        beat(6'd1, 1'b0, 1'b0);
        beat(6'd2, 1'b1, 1'b0);
        bus.in_valid  = 1'b1;
        bus.in_data   = 6'd9;
        bus.in_last   = 1'b1;
        bus.sat_en    = 1'b0;
        bus.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1 || bus.out_data !== 6'd3) begin
                errors++; $display("FAIL bp_hold[%0d]: got ready=%b valid=%b data=%0d want ready=0 valid=1 data=3",
                                   i, bus.in_ready, bus.out_valid, $signed(bus.out_data));
            end
            @(posedge clk);
            #1;
        end
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        checks++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            errors++; $display("FAIL bp_release: got ready=%b valid=%b want ready=1 valid=0",
                               bus.in_ready, bus.out_valid);
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.in_data  = 'x;
        bus.in_last  = 1'bx;
        bus.sat_en   = 1'bx;
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== 6'd9) begin
            errors++; $display("FAIL bp_next_burst: got valid=%b data=%0d want valid=1 data=9",
                               bus.out_valid, $signed(bus.out_data));
        end
        checks++;
        if (bus.out_overflow !== 1'b0 || bus.out_ovf_count !== 4'd0) begin
            errors++; $display("FAIL bp_next_flags: got ovf=%b cnt=%0d want ovf=0 cnt=0",
                               bus.out_overflow, bus.out_ovf_count);
        end
        take_result();
    endtask

    task automatic test_back_to_back();
        // Wrap burst followed immediately by a clean one: flags must not leak.
        beat(6'd20, 1'b0, 1'b0);
        beat(6'd20, 1'b1, 1'b0);
        take_result();
        beat(6'd4, 1'b1, 1'b0);
        checks++;
        if (bus.out_data !== 6'd4 || bus.out_overflow !== 1'b0 || bus.out_ovf_count !== 4'd0) begin
            errors++; $display("FAIL b2b_clean: got data=%0d ovf=%b cnt=%0d want data=4 ovf=0 cnt=0",
                               $signed(bus.out_data), bus.out_overflow, bus.out_ovf_count);
        end
        take_result();
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_data   = 'x;
        bus.in_last   = 1'bx;
        bus.sat_en    = 1'bx;
        bus.out_ready = 1'b0;
        test_reset();
        test_no_overflow();
        test_wrap();
        test_saturation();
        test_counter_saturation();
        test_backpressure();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end
endmodule
